// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO peripheral.
//
// LED_W output lines, written directly or through set/clear/toggle aliases.
// SW_W switch inputs, each passed through a synchroniser and a per-bit
// debouncer. A debounced rising edge latches a sticky EDGE bit, which is
// cleared by writing 1. Any EDGE bit whose MASK bit is set raises irq_o.
//
// Register map (word offset = addr_i[4:2], read data zero-extended):
//   0 LED      RW   1 LED_SET  W (reads LED)   2 LED_CLR  W (reads LED)
//   3 LED_TGL  W (reads LED)   4 SW       RO   5 EDGE     R/W1C
//   6 MASK     RW   7 reserved (reads 0, writes ignored)
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      asynchronous reset, active low
//   sel_i    block selected by the address decoder
//   write_i  CPU write strobe, effective only together with sel_i
//   addr_i   CPU data address, only bits [4:2] are decoded
//   data_i   CPU write data
//   data_o   read data, combinational from addr_i[4:2] and register state
//   sw_i     raw asynchronous switch inputs
//   led_o    LED register
//   irq_o    level interrupt, |(EDGE & MASK)
module mmio_gpio #(
  parameter int               LED_W           = 4,
  parameter int               SW_W            = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [LED_W-1:0] LED_RESET       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [SW_W-1:0]   sw_i,
  output logic [LED_W-1:0]  led_o,
  output logic              irq_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFF_LED  = 3'd0;
  localparam logic [2:0] OFF_SET  = 3'd1;
  localparam logic [2:0] OFF_CLR  = 3'd2;
  localparam logic [2:0] OFF_TGL  = 3'd3;
  localparam logic [2:0] OFF_SW   = 3'd4;
  localparam logic [2:0] OFF_EDGE = 3'd5;
  localparam logic [2:0] OFF_MASK = 3'd6;

  logic [2:0]       off;
  logic             wr_en;
  logic             unused_bits;

  logic [SW_W-1:0]  sync_q [SYNC_STAGES];
  logic [SW_W-1:0]  synced;
  logic [SW_W-1:0]  deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [SW_W];
  logic [CNT_W-1:0] cnt_d [SW_W];
  logic [SW_W-1:0]  rise;

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  edge_q, edge_d;
  logic [SW_W-1:0]  mask_q, mask_d;

  assign off         = addr_i[4:2];
  assign wr_en       = sel_i & write_i;
  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], data_i};
  assign synced      = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous switch inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Debounce: the counter tracks consecutive cycles in which the synced
  // value disagrees with the debounced value; any agreement restarts it.
  always_comb begin
    deb_d = deb_q;
    rise  = '0;
    for (int b = 0; b < SW_W; b++) begin
      cnt_d[b] = '0;
      if (synced[b] != deb_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          deb_d[b] = ~deb_q[b];
          rise[b]  = ~deb_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Register writes; a debounced rise overrides a same-cycle W1C
  always_comb begin
    led_d  = led_q;
    edge_d = edge_q;
    mask_d = mask_q;
    if (wr_en) begin
      case (off)
        OFF_LED:  led_d  = data_i[LED_W-1:0];
        OFF_SET:  led_d  = led_q | data_i[LED_W-1:0];
        OFF_CLR:  led_d  = led_q & ~data_i[LED_W-1:0];
        OFF_TGL:  led_d  = led_q ^ data_i[LED_W-1:0];
        OFF_EDGE: edge_d = edge_q & ~data_i[SW_W-1:0];
        OFF_MASK: mask_d = data_i[SW_W-1:0];
        default:  ;
      endcase
    end
    edge_d = edge_d | rise;
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q  <= LED_RESET;
      deb_q  <= '0;
      edge_q <= '0;
      mask_q <= '0;
      for (int b = 0; b < SW_W; b++) cnt_q[b] <= '0;
    end else begin
      led_q  <= led_d;
      deb_q  <= deb_d;
      edge_q <= edge_d;
      mask_q <= mask_d;
      for (int b = 0; b < SW_W; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  // Read mux, valid regardless of sel_i
  always_comb begin
    data_o = '0;
    case (off)
      OFF_LED, OFF_SET, OFF_CLR, OFF_TGL: data_o[LED_W-1:0] = led_q;
      OFF_SW:   data_o[SW_W-1:0] = deb_q;
      OFF_EDGE: data_o[SW_W-1:0] = edge_q;
      OFF_MASK: data_o[SW_W-1:0] = mask_q;
      default:  ;
    endcase
  end

  assign led_o = led_q;
  assign irq_o = |(edge_q & mask_q);

endmodule

// File: tb/tb_mmio_gpio.sv
module tb_mmio_gpio;

  localparam int LED_W = 4;
  localparam int SW_W  = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;

  logic              clk;
  logic              rst;
  logic              sel_i;
  logic              write_i;
  logic [31:0]       addr_i;
  logic [31:0]       data_i;
  logic [31:0]       data_o;
  logic [SW_W-1:0]   sw_i;
  logic [LED_W-1:0]  led_o;
  logic              irq_o;

  int total = 0;
  int bad   = 0;

  mmio_gpio #(
    .LED_W(LED_W), .SW_W(SW_W), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB), .LED_RESET('0)
  ) dut (
    .clk(clk), .rst(rst), .sel_i(sel_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .sw_i(sw_i), .led_o(led_o), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: synced input is the raw input seen SYNC cycles ago;
  // a bit's debounced value flips once it has disagreed with the synced
  // value for DEB consecutive cycles.
  logic [LED_W-1:0] m_led;
  logic [SW_W-1:0]  m_deb, m_edge, m_mask;
  logic [SW_W-1:0]  m_hist[$];
  int               m_run[SW_W];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0, 3'd1, 3'd2, 3'd3: return 32'(m_led);
      3'd4: return 32'(m_deb);
      3'd5: return 32'(m_edge);
      3'd6: return 32'(m_mask);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_led  = '0;
    m_deb  = '0;
    m_edge = '0;
    m_mask = '0;
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_front('0);
    for (int b = 0; b < SW_W; b++) m_run[b] = 0;
  endtask

  task automatic model_step(input logic sel, input logic wr, input logic [31:0] addr,
                            input logic [31:0] din, input logic [SW_W-1:0] sw);
    logic [SW_W-1:0] synced;
    logic [SW_W-1:0] rise;
    synced = m_hist[SYNC-1];
    rise   = '0;
    for (int b = 0; b < SW_W; b++) begin
      if (synced[b] != m_deb[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DEB) begin
          m_deb[b] = synced[b];
          m_run[b] = 0;
          rise[b]  = synced[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_hist.push_front(sw);
    void'(m_hist.pop_back());
    if (sel && wr) begin
      case (addr[4:2])
        3'd0: m_led = din[LED_W-1:0];
        3'd1: m_led = m_led | din[LED_W-1:0];
        3'd2: m_led = m_led & ~din[LED_W-1:0];
        3'd3: m_led = m_led ^ din[LED_W-1:0];
        3'd5: m_edge = m_edge & ~din[SW_W-1:0];
        3'd6: m_mask = din[SW_W-1:0];
        default: ;
      endcase
    end
    m_edge = m_edge | rise;
  endtask

  // One clock: drive inputs, let the edge happen, compare on the falling edge.
  task automatic cycle(input logic sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] din, input logic [SW_W-1:0] sw);
    sel_i   = sel;
    write_i = wr;
    addr_i  = addr;
    data_i  = din;
    sw_i    = sw;
    @(posedge clk);
    model_step(sel, wr, addr, din, sw);
    @(negedge clk);
    chk("led_o", 32'(led_o), 32'(m_led));
    chk("irq_o", 32'(irq_o), 32'(|(m_edge & m_mask)));
    chk("data_o", data_o, model_read(addr[4:2]));
  endtask

  task automatic do_reset(input logic [SW_W-1:0] sw);
    rst     = 1'b0;
    sel_i   = 1'b0;
    write_i = 1'b0;
    data_i  = '0;
    sw_i    = sw;
    model_reset();
    #1;
    chk("rst_led", 32'(led_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    for (int k = 0; k < 8; k++) begin
      addr_i = 32'(k * 4);
      #1;
      chk("rst_read", data_o, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    sel_i   = 1'b0;
    write_i = 1'b0;
    addr_i  = '0;
    data_i  = '0;
    sw_i    = '0;

    // Reset state and first read
    do_reset('0);
    cycle(0, 0, 32'h0, 0, 0);
    chk("read0_after_rst", data_o, 32'd0);

    // LED write modes
    cycle(1, 1, 32'h00, 32'h5, 0); chk("led_wr",  32'(led_o), 32'h5);
    cycle(1, 1, 32'h04, 32'h2, 0); chk("led_set", 32'(led_o), 32'h7);
    cycle(1, 1, 32'h08, 32'h4, 0); chk("led_clr", 32'(led_o), 32'h3);
    cycle(1, 1, 32'h0C, 32'h9, 0); chk("led_tgl", 32'(led_o), 32'hA);
    cycle(0, 1, 32'h00, 32'hF, 0); chk("led_nosel", 32'(led_o), 32'hA);
    cycle(1, 1, 32'hFFFF_FFE3, 32'h3, 0); chk("led_addr_alias", 32'(led_o), 32'h3);

    // Switch 0 rises and is held: SW visible from edge 6
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 32'h10, 0, 4'h1);
      chk("sw_latency", data_o, (i >= 6) ? 32'h1 : 32'h0);
    end
    cycle(0, 0, 32'h14, 0, 4'h1);
    chk("edge_set", data_o, 32'h1);
    chk("irq_masked", 32'(irq_o), 32'd0);

    // Interrupt masking and W1C
    cycle(1, 1, 32'h18, 32'h1, 4'h1); chk("irq_on", 32'(irq_o), 32'd1);
    cycle(1, 1, 32'h14, 32'h1, 4'h1); chk("irq_w1c", 32'(irq_o), 32'd0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 32'h14, 0, 4'h0);
    chk("fall_no_edge", data_o, 32'h0);
    for (int i = 1; i <= 5; i++) cycle(0, 0, 32'h10, 0, 4'h1);
    cycle(1, 1, 32'h14, 32'h1, 4'h1);
    cycle(0, 0, 32'h14, 0, 4'h1);
    chk("w1c_race_edge", data_o, 32'h1);
    chk("w1c_race_irq", 32'(irq_o), 32'd1);
    cycle(1, 1, 32'h18, 32'h0, 4'h1); chk("irq_mask_off", 32'(irq_o), 32'd0);

    // Glitch filter on switch 2
    do_reset('0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'h10, 0, 4'h4);
    for (int i = 0; i < 8; i++) cycle(0, 0, 32'h10, 0, 4'h0);
    chk("glitch_sw", data_o, 32'h0);
    cycle(0, 0, 32'h14, 0, 4'h0);
    chk("glitch_edge", data_o, 32'h0);
    for (int i = 1; i <= 6; i++) cycle(0, 0, 32'h10, 0, (i <= 4) ? 4'h4 : 4'h0);
    chk("pulse4_sw", data_o, 32'h4);
    cycle(0, 0, 32'h14, 0, 4'h0);
    chk("pulse4_edge", data_o, 32'h4);

    // Reset in the middle of a debounce count
    do_reset('0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 32'h10, 0, 4'h2);
    do_reset(4'h2);
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 0, 32'h10, 0, 4'h2);
      chk("rst_mid_deb", data_o, (i >= 6) ? 32'h2 : 32'h0);
    end
    cycle(1, 1, 32'h1C, 32'hFFFF_FFFF, 4'h2);
    chk("reserved_rd", data_o, 32'h0);
    chk("reserved_wr_led", 32'(led_o), 32'h0);

    // Randomised traffic against the model
    begin
      logic [SW_W-1:0] sw_r;
      sw_r = '0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 11) == 0) sw_r = SW_W'($urandom);
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, sw_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
